// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared fetch-stage constants and state encoding.
package cpu_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD
  } fetch_state_e;
endpackage

// File: rtl/fetch_pc_sequencer_if.sv
// Instruction-memory, IF/ID and redirect signals of the fetch stage.
interface fetch_pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        id_stall;
  logic        id_jump;
  logic [31:0] jump_target;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic        flush_id;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc4, flush_id,
    input  imem_ready, imem_rdata, id_stall, id_jump, jump_target,
           ex_br_taken, ex_br_target
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc4, flush_id,
    output imem_ready, imem_rdata, id_stall, id_jump, jump_target,
           ex_br_taken, ex_br_target
  );
endinterface

// File: rtl/fetch_pc_sequencer_next_pc_mux.sv
// Priority select of the next fetch address: EX branch, then ID jump, then pc+4.
module next_pc_mux
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        id_stall_i,
  input  logic        id_jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        ex_br_taken_i,
  input  logic [31:0] ex_br_target_i,
  output logic [31:0] pc_seq_o,
  output logic        redirect_o,
  output logic [31:0] target_o
);
  always_comb begin
    pc_seq_o   = pc_i + PC_INC;
    redirect_o = 1'b0;
    target_o   = pc_seq_o;
    // A stalled ID may still hold a jump; it is only acted on once ID advances.
    if (ex_br_taken_i) begin
      redirect_o = 1'b1;
      target_o   = ex_br_target_i;
    end else if (id_jump_i && !id_stall_i) begin
      redirect_o = 1'b1;
      target_o   = jump_target_i;
    end
  end
endmodule

// File: rtl/fetch_pc_sequencer.sv
// Program-counter owner and instruction-memory fetch handshake for the IF stage.
module fetch_pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  fetch_pc_sequencer_if.master bus
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, addr_q, addr_d;
  logic         pend_q, pend_d, kill_q, kill_d;
  logic         vld_q, vld_d;
  logic [31:0]  instr_q, instr_d, pc4_q, pc4_d;
  logic [31:0]  pc_seq, target;
  logic         redirect, req;

  next_pc_mux u_next_pc_mux (
    .pc_i          (pc_q),
    .id_stall_i    (bus.id_stall),
    .id_jump_i     (bus.id_jump),
    .jump_target_i (bus.jump_target),
    .ex_br_taken_i (bus.ex_br_taken),
    .ex_br_target_i(bus.ex_br_target),
    .pc_seq_o      (pc_seq),
    .redirect_o    (redirect),
    .target_o      (target)
  );

  // A new request starts only when the buffer can take its data; an issued one is held.
  assign req    = !rst && (state_q == FETCH) && (pend_q || !vld_q || !bus.id_stall);
  assign addr_d = pend_q ? addr_q : pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    pend_d  = req && !bus.imem_ready;
    vld_d   = vld_q && bus.id_stall;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    unique case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        if (!req) begin
          state_d = HOLD;
        end else if (bus.imem_ready) begin
          if (kill_q) begin
            kill_d = 1'b0;
          end else if (!vld_q || !bus.id_stall) begin
            vld_d   = 1'b1;
            instr_d = bus.imem_rdata;
            pc4_d   = pc_seq;
            pc_d    = pc_seq;
          end else begin
            // Stall rose while in flight: drop the word, pc unchanged, refetch after HOLD.
            state_d = HOLD;
          end
        end
      end
      HOLD:    if (!bus.id_stall) state_d = FETCH;
      default: state_d = BOOT;
    endcase
    if (redirect) begin
      pc_d    = target;
      vld_d   = 1'b0;
      kill_d  = req && !bus.imem_ready;
      state_d = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      pend_q  <= 1'b0;
      kill_q  <= 1'b0;
      vld_q   <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      kill_q  <= kill_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = addr_d;
  assign bus.if_valid  = vld_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc4    = pc4_q;
  assign bus.flush_id  = bus.ex_br_taken && !rst;
endmodule

// File: doc/fetch_pc_sequencer.md
# fetch_pc_sequencer

Owns the program counter and drives the instruction-memory fetch handshake for the MIPS pipeline. Each cycle it chooses the next fetch address from three sources: sequential PC+4, a jump target resolved in ID, or a branch target resolved in EX. It presents fetched instructions to IF/ID with a valid/stall handshake. On a redirect it flushes wrong-path instructions, including a fetch that is still outstanding in memory.

## Interface
- RESET_PC, 32'h0000_3000, fetch address after reset
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held until imem_ready
- imem_addr  out  32  fetch address; stable while imem_req=1
- imem_ready  in  1  one-cycle response strobe; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- if_valid  out  1  if_instr/if_pc4 hold a valid instruction
- if_instr  out  32  instruction to IF/ID
- if_pc4  out  32  fetch address + 4 for that instruction
- id_stall  in  1  IF/ID cannot accept; hold if_* outputs
- id_jump  in  1  ID decoded J/JAL; jump_target valid
- jump_target  in  32  {pc4[31:28], idx26, 2'b00}, computed in ID
- ex_br_taken  in  1  EX resolved a taken branch
- ex_br_target  in  32  pc4 + (sext(imm16) << 2), computed in EX
- flush_id  out  1  kill the instruction now in ID (wrong path)

## Operation
- Registers: pc (32), out buffer (if_valid, if_instr, if_pc4), state, kill flag.
- States:
  - BOOT: one cycle after reset; imem_req=0.
  - FETCH: imem_req=1, imem_addr=pc, waiting for imem_ready.
  - HOLD: buffer full and id_stall=1; no request issued.
- Redirect priority: ex_br_taken > id_jump > sequential.
- A redirect is sampled only when id_stall=0, except ex_br_taken, which is always honoured.
- Redirect in any state:
  - pc <= target.
  - if_valid <= 0 on the next edge.
  - flush_id=1 combinationally in the same cycle, only for ex_br_taken; for a jump, ID itself is correct.
  - If a fetch is outstanding (FETCH, ready not yet seen), set kill.
  - Keep imem_addr stable until that response arrives, then discard it and reissue at the new pc.
- Transitions:
  - BOOT->FETCH.
  - FETCH + imem_ready, kill=0, and (id_stall=0 or buffer empty): load buffer {1, rdata, pc+4}; pc <= pc+4; stay in FETCH.
  - FETCH + imem_ready, kill=0, buffer full and id_stall=1: capture into buffer is blocked. To avoid this, a request is issued only when the buffer will be free; FETCH therefore starts only when if_valid=0 or id_stall=0, otherwise go to HOLD.
  - FETCH + imem_ready, kill=1: drop data; clear kill; reissue at pc.
  - HOLD + id_stall=0: go to FETCH; if_valid drops unless refilled.
- Arithmetic: all addresses are 32-bit, mod 2^32. pc+4 at 32'hFFFF_FFFC wraps to 0.
- A redirect target with addr[1:0]≠0 is used as given; the block does not check alignment.

## Timing
- Reset values (while rst=1 and the cycle after):
  - pc=RESET_PC, state=BOOT, kill=0.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_instr=0, if_pc4=0, flush_id=0.
- First imem_req rises 1 cycle after rst deasserts.
- Zero-wait memory (ready in the same cycle as req): one instruction per cycle. Latency is imem_ready edge -> if_valid on the next edge.
- if_* are held constant while if_valid=1 and id_stall=1.
- Simultaneous ex_br_taken and id_jump: the branch wins and the jump is dropped, since it was wrong-path.
- Simultaneous redirect and imem_ready: the response is discarded and the next request goes to the target. kill is not set.
- rst mid-fetch: abandon the request immediately; imem_req=0 next cycle. Memory must tolerate a dropped request.

## Structure
- Shared package `cpu_pkg`:
  - RESET_PC default.
  - state enum {BOOT, FETCH, HOLD}.
  - constant PC_INC=32'd4.
- One natural sub-module, `next_pc_mux`: combinational priority select of branch, jump, or pc+4, with a redirect flag. Everything else is a single always block plus output assigns.

## Test plan
- Reset release, zero-wait memory, no stalls -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; if_pc4 0x3004 one cycle after the first ready.
- id_stall=1 for 3 cycles with if_instr=0x2008_0005 -> if_* are unchanged for all 3 cycles; no new imem_req until stall drops.
- id_jump=1 with jump_target=0x0000_3040 while fetching 0x3008 -> next imem_addr=0x3040; flush_id stays 0.
- ex_br_taken (target 0x3100) and id_jump (target 0x3040) in the same cycle -> flush_id=1; next address 0x3100; if_valid=0 next cycle.
- ex_br_taken to 0x3200 while a 3-wait fetch of 0x300C is outstanding -> 0x300C data is discarded on ready; next request is 0x3200; if_valid never shows 0x300C data.
- rst pulsed mid-fetch -> imem_req=0 next cycle; restart at 0x3000; all outputs at their reset values.
